// File: rtl/prg_dma_loader.sv
// Owns the PET DMA write port during HPS downloads: parses .PRG headers, streams the payload
// into RAM, patches the BASIC end-of-program pointer, and loads system-ROM images at $8000.
module prg_dma_loader #(
    parameter logic [7:0]  PRG_INDEX = 8'h41,
    parameter logic [7:0]  ROM_INDEX = 8'h02,
    parameter logic [15:0] RAM_TOP   = 16'h8000,
    parameter logic [15:0] VARTAB    = 16'h002A
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_din,
    output logic        dma_we,
    output logic        rom_hold,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        StIdle, StHdrLo, StHdrHi, StPrgData, StRomData, StFixLo, StFixGap, StFixHi
    } state_t;

    state_t      state_q;
    state_t      start_state;
    logic        dl_q;
    logic        pend_q;
    logic [7:0]  pend_idx_q;
    logic [15:0] ptr_q;
    logic        dl_rise;
    logic        dl_fall;
    logic [7:0]  start_idx;

    assign dl_rise = ioctl_download & ~dl_q;
    assign dl_fall = ~ioctl_download & dl_q;

    // A start latched during the fixup takes priority over the live index.
    always_comb begin
        start_idx   = pend_q ? pend_idx_q : ioctl_index;
        start_state = StIdle;
        if (start_idx == PRG_INDEX) begin
            start_state = StHdrLo;
        end else if (start_idx == ROM_INDEX) begin
            start_state = StRomData;
        end
    end

    assign busy       = (state_q != StIdle);
    assign ioctl_wait = (state_q == StFixLo) || (state_q == StFixGap) || (state_q == StFixHi);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            dl_q       <= 1'b0;
            pend_q     <= 1'b0;
            pend_idx_q <= 8'h00;
            ptr_q      <= 16'h0000;
            dma_addr   <= 16'h0000;
            dma_din    <= 8'h00;
            dma_we     <= 1'b0;
            rom_hold   <= 1'b0;
            err        <= 1'b0;
        end else begin
            dl_q     <= ioctl_download;
            dma_we   <= 1'b0;
            // Stays high for one cycle after ROM_DATA is left.
            rom_hold <= (state_q == StRomData);
            unique case (state_q)
                StIdle: begin
                    if (dl_rise) begin
                        state_q <= start_state;
                        if (start_state == StHdrLo)   err      <= 1'b0;
                        if (start_state == StRomData) rom_hold <= 1'b1;
                    end
                end
                StHdrLo: begin
                    if (dl_fall) begin
                        err     <= 1'b1;
                        state_q <= StIdle;
                    end else if (ioctl_wr) begin
                        ptr_q[7:0] <= ioctl_dout;
                        state_q    <= StHdrHi;
                    end
                end
                StHdrHi: begin
                    if (dl_fall) begin
                        err     <= 1'b1;
                        state_q <= StIdle;
                    end else if (ioctl_wr) begin
                        ptr_q[15:8] <= ioctl_dout;
                        state_q     <= StPrgData;
                    end
                end
                StPrgData: begin
                    if (ioctl_wr) begin
                        if (ptr_q < RAM_TOP) begin
                            dma_we   <= 1'b1;
                            dma_addr <= ptr_q;
                            dma_din  <= ioctl_dout;
                            ptr_q    <= ptr_q + 16'd1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    if (dl_fall) state_q <= StFixLo;
                end
                StRomData: begin
                    if (ioctl_wr && (ioctl_addr < 25'h8000)) begin
                        dma_we   <= 1'b1;
                        dma_addr <= {1'b1, ioctl_addr[14:0]};
                        dma_din  <= ioctl_dout;
                    end
                    if (dl_fall) state_q <= StIdle;
                end
                StFixLo: begin
                    dma_we   <= 1'b1;
                    dma_addr <= VARTAB;
                    dma_din  <= ptr_q[7:0];
                    state_q  <= StFixGap;
                    if (dl_rise) begin
                        pend_q     <= 1'b1;
                        pend_idx_q <= ioctl_index;
                    end
                end
                StFixGap: begin
                    state_q <= StFixHi;
                    if (dl_rise) begin
                        pend_q     <= 1'b1;
                        pend_idx_q <= ioctl_index;
                    end
                end
                StFixHi: begin
                    dma_we   <= 1'b1;
                    dma_addr <= VARTAB + 16'd1;
                    dma_din  <= ptr_q[15:8];
                    pend_q   <= 1'b0;
                    if (pend_q || dl_rise) begin
                        state_q <= start_state;
                        if (start_state == StHdrLo)   err      <= 1'b0;
                        if (start_state == StRomData) rom_hold <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prg_dma_loader.sv
// Directed bench for prg_dma_loader: PRG load, overflow, ROM load, truncated header,
// pending start during fixup, and reset in mid-load.
module tb_prg_dma_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'h00;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = 25'h0;
    logic [7:0]  ioctl_dout = 8'h00;
    logic        ioctl_wait;
    logic [15:0] dma_addr;
    logic [7:0]  dma_din;
    logic        dma_we;
    logic        rom_hold;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [15:0] log_addr[$];
    logic [7:0]  log_data[$];
    int          log_cyc[$];

    prg_dma_loader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .dma_addr       (dma_addr),
        .dma_din        (dma_din),
        .dma_we         (dma_we),
        .rom_hold       (rom_hold),
        .busy           (busy),
        .err            (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dma_we === 1'b1) begin
            log_addr.push_back(dma_addr);
            log_data.push_back(dma_din);
            log_cyc.push_back(cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_log(input string tag, input int i, input logic [15:0] a,
                           input logic [7:0] d);
        logic [23:0] obs;
        obs = 'x;
        if (i < log_addr.size()) obs = {log_addr[i], log_data[i]};
        chk(tag, {8'h00, obs}, {8'h00, a, d});
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic strobe(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick();
    endtask

    function automatic logic [7:0] rom_byte(input int i);
        return 8'(i) ^ 8'(i >> 8);
    endfunction

    initial begin
        int hold_bad;
        int bad;

        // Reset state
        repeat (3) tick();
        chk("rst_flags", {27'h0, dma_we, rom_hold, busy, err, ioctl_wait}, 32'h0);
        chk("rst_bus", {8'h00, dma_addr, dma_din}, 32'h0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Normal PRG load
        clear_log();
        start_dl(8'h41);
        chk("prg_busy", {busy, err}, 2'b10);
        strobe(25'd0, 8'h01);
        strobe(25'd1, 8'h04);
        chk("hdr_no_we", dma_we, 1'b0);
        strobe(25'd2, 8'hAA);
        chk("prg_we_n1", {dma_we, dma_addr, dma_din}, {1'b1, 16'h0401, 8'hAA});
        strobe(25'd3, 8'hBB);
        strobe(25'd4, 8'hCC);
        ioctl_download = 1'b0;
        tick();
        chk("fix_f1", {dma_we, ioctl_wait}, 2'b01);
        tick();
        chk("fix_lo", {dma_we, dma_addr, dma_din}, {1'b1, 16'h002A, 8'h04});
        tick();
        chk("fix_gap", {dma_we, ioctl_wait, dma_addr, dma_din}, {2'b01, 16'h002A, 8'h04});
        tick();
        chk("fix_hi", {dma_we, dma_addr, dma_din}, {1'b1, 16'h002B, 8'h04});
        tick();
        chk("fix_done", {busy, ioctl_wait, err}, 3'b000);
        chk_log("prg_w0", 0, 16'h0401, 8'hAA);
        chk_log("prg_w1", 1, 16'h0402, 8'hBB);
        chk_log("prg_w2", 2, 16'h0403, 8'hCC);
        chk_log("prg_w3", 3, 16'h002A, 8'h04);
        chk_log("prg_w4", 4, 16'h002B, 8'h04);
        chk("prg_log_n", log_addr.size(), 5);
        chk("prg_b2b", log_cyc[2] - log_cyc[0], 2);
        chk("fix_spacing", log_cyc[4] - log_cyc[3], 2);

        // Overflow at RAM_TOP
        clear_log();
        start_dl(8'h41);
        strobe(25'd0, 8'hFE);
        strobe(25'd1, 8'h7F);
        strobe(25'd2, 8'h11);
        strobe(25'd3, 8'h22);
        strobe(25'd4, 8'h33);
        strobe(25'd5, 8'h44);
        ioctl_download = 1'b0;
        repeat (6) tick();
        chk_log("ovf_w0", 0, 16'h7FFE, 8'h11);
        chk_log("ovf_w1", 1, 16'h7FFF, 8'h22);
        chk_log("ovf_w2", 2, 16'h002A, 8'h00);
        chk_log("ovf_w3", 3, 16'h002B, 8'h80);
        chk("ovf_log_n", log_addr.size(), 4);
        chk("ovf_err", err, 1'b1);

        // System ROM load, 0x9000 bytes
        clear_log();
        start_dl(8'h02);
        chk("rom_hold_on", {rom_hold, busy}, 2'b11);
        hold_bad = 0;
        for (int i = 0; i < 'h9000; i++) begin
            strobe(25'(i), rom_byte(i));
            if (rom_hold !== 1'b1) hold_bad++;
        end
        ioctl_download = 1'b0;
        tick();
        chk("rom_hold_tail", {rom_hold, busy}, 2'b10);
        tick();
        chk("rom_hold_off", rom_hold, 1'b0);
        repeat (4) tick();
        chk("rom_hold_run", hold_bad, 0);
        chk("rom_wr_count", log_addr.size(), 32'h8000);
        bad = 0;
        for (int i = 0; i < log_addr.size(); i++) begin
            if (log_addr[i] !== 16'(32'h8000 + i) || log_data[i] !== rom_byte(i)) bad++;
        end
        chk("rom_content", bad, 0);

        // Truncated header
        clear_log();
        start_dl(8'h41);
        chk("trunc_err_clr", err, 1'b0);
        strobe(25'd0, 8'h01);
        ioctl_download = 1'b0;
        chk("trunc_busy_f", busy, 1'b1);
        tick();
        chk("trunc_f1", {busy, err}, 2'b01);
        repeat (4) tick();
        chk("trunc_no_we", log_addr.size(), 0);

        // Second download starts during the fixup
        clear_log();
        start_dl(8'h41);
        strobe(25'd0, 8'h00);
        strobe(25'd1, 8'h10);
        strobe(25'd2, 8'h55);
        chk("pend_byte", {dma_we, dma_addr, dma_din}, {1'b1, 16'h1000, 8'h55});
        tick();
        chk("pend_we_low", dma_we, 1'b0);
        ioctl_download = 1'b0;
        tick();
        ioctl_download = 1'b1;
        tick();
        chk("pend_wait_f2", {ioctl_wait, dma_we}, 2'b11);
        tick();
        chk("pend_wait_f3", ioctl_wait, 1'b1);
        tick();
        chk("pend_fix_hi", {dma_we, dma_addr, dma_din, ioctl_wait, busy},
            {1'b1, 16'h002B, 8'h10, 2'b01});
        strobe(25'd0, 8'h00);
        strobe(25'd1, 8'h20);
        strobe(25'd2, 8'h66);
        ioctl_download = 1'b0;
        repeat (6) tick();
        chk_log("pend_w0", 0, 16'h1000, 8'h55);
        chk_log("pend_w1", 1, 16'h002A, 8'h01);
        chk_log("pend_w2", 2, 16'h002B, 8'h10);
        chk_log("pend_w3", 3, 16'h2000, 8'h66);
        chk_log("pend_w4", 4, 16'h002A, 8'h01);
        chk_log("pend_w5", 5, 16'h002B, 8'h20);
        chk("pend_log_n", log_addr.size(), 6);

        // Reset in mid-load, then a clean load
        clear_log();
        start_dl(8'h41);
        strobe(25'd0, 8'h00);
        strobe(25'd1, 8'h30);
        for (int i = 0; i < 10; i++) strobe(25'(2 + i), 8'(i));
        tick();
        #2;
        reset_n = 1'b0;
        ioctl_download = 1'b0;
        #1;
        chk("rst_mid_flags", {27'h0, dma_we, busy, ioctl_wait, rom_hold, err}, 32'h0);
        chk("rst_mid_bus", {8'h00, dma_addr, dma_din}, 32'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        chk("rst_no_fix", log_addr.size(), 10);
        chk_log("rst_last", 9, 16'h3009, 8'h09);
        clear_log();
        start_dl(8'h41);
        strobe(25'd0, 8'h00);
        strobe(25'd1, 8'h05);
        strobe(25'd2, 8'h77);
        ioctl_download = 1'b0;
        repeat (6) tick();
        chk_log("post_w0", 0, 16'h0500, 8'h77);
        chk_log("post_w1", 1, 16'h002A, 8'h01);
        chk_log("post_w2", 2, 16'h002B, 8'h05);
        chk("post_log_n", log_addr.size(), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
